// File: rtl/script_byte_emitter_pkg.sv
// Shared opcode constants, emitter state type and helpers for script_byte_emitter.
package script_byte_emitter_pkg;

  localparam logic [7:0] OP_0            = 8'h00;
  localparam logic [7:0] OP_1NEGATE      = 8'h4f;
  localparam logic [7:0] OP_1            = 8'h51;
  localparam logic [7:0] MAX_DIRECT_PUSH = 8'h4b;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPB,
    S_LEN,
    S_DATA,
    S_EVAL,
    S_ERR
  } emit_state_t;

  // Largest push the loader accepts as a direct length-prefixed push.
  function automatic int unsigned max_bytes(input int unsigned stack_width);
    return ((stack_width / 8) < 32'(MAX_DIRECT_PUSH)) ? (stack_width / 8) : 32'(MAX_DIRECT_PUSH);
  endfunction

  // Bytes 0x01..0x4b are read by the loader as push-length prefixes.
  function automatic logic is_direct_push(input logic [7:0] b);
    return (b != OP_0) && (b <= MAX_DIRECT_PUSH);
  endfunction

endpackage

// File: rtl/script_byte_emitter_if.sv
// Item-in / byte-out handshake bundle between the script source, the emitter and the loader.
interface script_byte_emitter_if #(
  parameter int unsigned STACK_WIDTH = 512,
  parameter int unsigned LEN_W       = 7
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_is_op;
  logic [7:0]             in_op;
  logic [LEN_W-1:0]       in_len;
  logic [STACK_WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   out_ready;
  logic [7:0]             script_data;
  logic                   script_put;
  logic                   script_evaluate;

  modport master (
    output in_valid, in_is_op, in_op, in_len, in_data, in_last, out_ready,
    input  in_ready, script_data, script_put, script_evaluate
  );

  modport slave (
    input  in_valid, in_is_op, in_op, in_len, in_data, in_last, out_ready,
    output in_ready, script_data, script_put, script_evaluate
  );
endinterface

// File: rtl/script_byte_emitter_push_shifter.sv
// Push-data alignment register: loads data MSB-aligned, presents the top byte, shifts by one byte per step.
module script_byte_emitter_push_shifter #(
  parameter int unsigned STACK_WIDTH = 512,
  parameter int unsigned LEN_W       = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_shift,
  input  logic [STACK_WIDTH-1:0] i_data,
  input  logic [LEN_W-1:0]       i_len,
  output logic [7:0]             o_top,
  output logic                   o_empty
);
  localparam int unsigned SH_W = $clog2(STACK_WIDTH) + 1;

  logic [STACK_WIDTH-1:0] r_sr;
  logic [LEN_W-1:0]       r_cnt;
  logic [SH_W-1:0]        w_shamt;

  // Shift the low in_len bytes up so the most significant one sits at the top.
  assign w_shamt = SH_W'(STACK_WIDTH) - SH_W'({i_len, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= i_data << w_shamt;
      r_cnt <= i_len;
    end else if (i_shift) begin
      r_sr  <= r_sr << 8;
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  assign o_top   = r_sr[STACK_WIDTH-1 -: 8];
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/script_byte_emitter.sv
// Serializes opcode / data-push items into the script loader byte stream, ending with an evaluate pulse.
// Optional: define SCRIPT_EMIT_MINIMAL_EN to emit OP_1..OP_16 / OP_1NEGATE for small one-byte pushes.
module script_byte_emitter
  import script_byte_emitter_pkg::*;
#(
  parameter int unsigned STACK_WIDTH = 512,
  parameter int unsigned LEN_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  script_byte_emitter_if.slave  bus,
  output logic                  o_busy,
  output logic                  o_error
);
  localparam int unsigned MAX_BYTES = max_bytes(STACK_WIDTH);

  emit_state_t r_state;
  logic        r_in_ready;
  logic        r_put;
  logic [7:0]  r_data;
  logic        r_eval;
  logic        r_busy;
  logic        r_error;
  logic        r_last;

  logic        w_accept;
  logic        w_xfer;
  logic        w_shift;
  logic        w_bad;
  logic        w_single;
  logic [7:0]  w_single_byte;
  logic [7:0]  w_top;
  logic        w_sh_empty;

  assign w_accept = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
  assign w_xfer   = r_put && bus.out_ready;
  assign w_shift  = w_xfer && ((r_state == S_LEN) || ((r_state == S_DATA) && !w_sh_empty));

  script_byte_emitter_push_shifter #(
    .STACK_WIDTH(STACK_WIDTH),
    .LEN_W      (LEN_W)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_shift(w_shift),
    .i_data (bus.in_data),
    .i_len  (bus.in_len),
    .o_top  (w_top),
    .o_empty(w_sh_empty)
  );

  // Classify the offered item: encoding error, single-byte form, or length-prefixed push.
  always_comb begin
    w_bad         = 1'b0;
    w_single      = 1'b0;
    w_single_byte = OP_0;
    if (bus.in_is_op) begin
      w_bad         = is_direct_push(bus.in_op);
      w_single      = 1'b1;
      w_single_byte = bus.in_op;
    end else if (bus.in_len == '0) begin
      w_single      = 1'b1;
      w_single_byte = OP_0;
    end else if (32'(bus.in_len) > MAX_BYTES) begin
      w_bad = 1'b1;
    end
`ifdef SCRIPT_EMIT_MINIMAL_EN
    else if (bus.in_len == LEN_W'(1)) begin
      if ((bus.in_data[7:0] >= 8'h01) && (bus.in_data[7:0] <= 8'h10)) begin
        w_single      = 1'b1;
        w_single_byte = OP_1 - 8'h01 + bus.in_data[7:0];
      end else if (bus.in_data[7:0] == 8'h81) begin
        w_single      = 1'b1;
        w_single_byte = OP_1NEGATE;
      end
    end
`else
    else begin
      w_single = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_put      <= 1'b0;
      r_data     <= '0;
      r_eval     <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_last     <= bus.in_last;
            if (w_bad) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else if (w_single) begin
              r_state <= S_OPB;
              r_put   <= 1'b1;
              r_data  <= w_single_byte;
            end else begin
              r_state <= S_LEN;
              r_put   <= 1'b1;
              r_data  <= 8'(bus.in_len);
            end
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_state <= S_DATA;
            r_data  <= w_top;
          end
        end
        // Final byte of an item leaves via EVAL when it closes the script.
        S_OPB, S_DATA: begin
          if (w_xfer) begin
            if ((r_state == S_DATA) && !w_sh_empty) begin
              r_data <= w_top;
            end else begin
              r_put <= 1'b0;
              if (r_last) begin
                r_state <= S_EVAL;
                r_eval  <= 1'b1;
              end else begin
                r_state    <= S_IDLE;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b0;
              end
            end
          end
        end
        S_EVAL: begin
          r_state    <= S_IDLE;
          r_eval     <= 1'b0;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        S_ERR: begin
          r_put      <= 1'b0;
          r_in_ready <= 1'b0;
          r_error    <= 1'b1;
        end
        default: begin
          r_state <= S_ERR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready        = r_in_ready;
  assign bus.script_put      = r_put;
  assign bus.script_data     = r_data;
  assign bus.script_evaluate = r_eval;
  assign o_busy              = r_busy;
  assign o_error             = r_error;

endmodule

// File: tb/tb_script_byte_emitter.sv
// Self-checking bench for script_byte_emitter: vector table, hand-written corner sequences, random items vs model.
module tb_script_byte_emitter;

  typedef struct {
    bit           is_op;
    logic [7:0]   op;
    logic [6:0]   len;
    logic [511:0] data;
    bit           last;
  } item_t;

  typedef struct {
    item_t      it;
    int         exp_n;
    logic [7:0] exp_first;
    logic [7:0] exp_lastb;
    int         exp_eval;
  } vec_t;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, error;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  bit   rand_ready = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         eval_cyc[$];

  script_byte_emitter_if #(.STACK_WIDTH(512), .LEN_W(7)) bus ();

  script_byte_emitter #(.STACK_WIDTH(512), .LEN_W(7)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .o_busy (busy),
    .o_error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Sink-side observer: records transfers and evaluate pulses, and checks stall hold.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_put", 32'(bus.script_put), 32'd1);
        check("hold_data", 32'(bus.script_data), 32'(prev_data));
      end
      prev_stall = bus.script_put && !bus.out_ready;
      prev_data  = bus.script_data;
      if (bus.script_put && bus.out_ready) begin
        got_q.push_back(bus.script_data);
        got_cyc.push_back(cyc);
      end
      if (bus.script_evaluate) eval_cyc.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: byte stream the loader must see for one item, from the encoding rules.
  function automatic void model(input item_t it, output bit err, output bq_t q);
    q   = {};
    err = 1'b0;
    if (it.is_op) begin
      if ((it.op >= 8'd1) && (it.op <= 8'd75)) err = 1'b1;
      else q.push_back(it.op);
    end else if (it.len == 7'd0) begin
      q.push_back(8'h00);
    end else if (it.len > 7'd64) begin
      err = 1'b1;
    end else begin
`ifdef SCRIPT_EMIT_MINIMAL_EN
      logic [7:0] v;
      v = it.data[7:0];
      if ((it.len == 7'd1) && (v >= 8'd1) && (v <= 8'd16)) q.push_back(8'h50 + v);
      else if ((it.len == 7'd1) && (v == 8'h81)) q.push_back(8'h4f);
      else begin
        q.push_back(8'(it.len));
        for (int i = int'(it.len) - 1; i >= 0; i--) q.push_back(it.data[8*i +: 8]);
      end
`else
      q.push_back(8'(it.len));
      for (int i = int'(it.len) - 1; i >= 0; i--) q.push_back(it.data[8*i +: 8]);
`endif
    end
  endfunction

  function automatic item_t mk_item(input bit is_op, input logic [7:0] op, input logic [6:0] len,
                                    input logic [511:0] data, input bit last);
    item_t it;
    it.is_op = is_op; it.op = op; it.len = len; it.data = data; it.last = last;
    return it;
  endfunction

  function automatic vec_t mk_vec(input item_t it, input int n, input logic [7:0] f,
                                  input logic [7:0] lb, input int ev);
    vec_t v;
    v.it = it; v.exp_n = n; v.exp_first = f; v.exp_lastb = lb; v.exp_eval = ev;
    return v;
  endfunction

  task automatic reset_dut();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_item(input item_t it, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n > 50) begin
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.in_is_op = it.is_op;
    bus.in_op    = it.op;
    bus.in_len   = it.len;
    bus.in_data  = it.data;
    bus.in_last  = it.last;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if ((bus.in_ready && !bus.script_put) || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_item(input item_t it);
    bit ok;
    got_q.delete(); got_cyc.delete(); eval_cyc.delete();
    send_item(it, ok);
    check("send_accept", 32'(ok), 32'd1);
    if (ok) begin
      wait_done(ok);
      check("item_done", 32'(ok), 32'd1);
    end
  endtask

  initial begin
    vec_t         vecs[13];
    logic [511:0] pat;
    item_t        it;
    bit           ok;
    bit           exp_err;
    bq_t          exp_q;

    bus.in_valid = 1'b0; bus.in_is_op = 1'b0; bus.in_op = '0; bus.in_len = '0;
    bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

    for (int i = 0; i < 64; i++) pat[8*i +: 8] = 8'(i + 1);
    vecs[0]  = mk_vec(mk_item(1, 8'h76, 0, '0, 0), 1, 8'h76, 8'h76, 0);
    vecs[1]  = mk_vec(mk_item(1, 8'h00, 0, '0, 1), 1, 8'h00, 8'h00, 1);
    vecs[2]  = mk_vec(mk_item(1, 8'h4c, 0, '0, 0), 1, 8'h4c, 8'h4c, 0);
    vecs[3]  = mk_vec(mk_item(1, 8'hff, 0, '0, 1), 1, 8'hff, 8'hff, 1);
    vecs[4]  = mk_vec(mk_item(0, 8'h00, 0, '0, 0), 1, 8'h00, 8'h00, 0);
    vecs[5]  = mk_vec(mk_item(0, 8'h00, 3, 512'hAABBCC, 1), 4, 8'h03, 8'hCC, 1);
    vecs[6]  = mk_vec(mk_item(0, 8'h00, 2, 512'hDEAD1234, 0), 3, 8'h02, 8'h34, 0);
    vecs[7]  = mk_vec(mk_item(0, 8'h00, 64, pat, 1), 65, 8'h40, 8'h01, 1);
    vecs[10] = mk_vec(mk_item(0, 8'h00, 1, 512'h11, 0), 2, 8'h01, 8'h11, 0);
    vecs[12] = mk_vec(mk_item(0, 8'h00, 1, 512'h00, 0), 2, 8'h01, 8'h00, 0);
`ifdef SCRIPT_EMIT_MINIMAL_EN
    vecs[8]  = mk_vec(mk_item(0, 8'h00, 1, 512'h05, 0), 1, 8'h55, 8'h55, 0);
    vecs[9]  = mk_vec(mk_item(0, 8'h00, 1, 512'h81, 1), 1, 8'h4f, 8'h4f, 1);
    vecs[11] = mk_vec(mk_item(0, 8'h00, 1, 512'h10, 0), 1, 8'h60, 8'h60, 0);
`else
    vecs[8]  = mk_vec(mk_item(0, 8'h00, 1, 512'h05, 0), 2, 8'h01, 8'h05, 0);
    vecs[9]  = mk_vec(mk_item(0, 8'h00, 1, 512'h81, 1), 2, 8'h01, 8'h81, 1);
    vecs[11] = mk_vec(mk_item(0, 8'h00, 1, 512'h10, 0), 2, 8'h01, 8'h10, 0);
`endif

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_put", 32'(bus.script_put), 32'd0);
    check("rst_data", 32'(bus.script_data), 32'd0);
    check("rst_eval", 32'(bus.script_evaluate), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // OP_DUP latency and in_ready return.
    got_q.delete(); got_cyc.delete(); eval_cyc.delete();
    send_item(mk_item(1, 8'h76, 0, '0, 0), ok);
    check("dup_accept", 32'(ok), 32'd1);
    @(negedge clk);
    check("dup_put_n1", 32'(bus.script_put), 32'd1);
    check("dup_data_n1", 32'(bus.script_data), 32'h76);
    check("dup_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("dup_put_n2", 32'(bus.script_put), 32'd0);
    check("dup_ready_n2", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("dup_count", 32'(got_q.size()), 32'd1);
    check("dup_no_eval", 32'(eval_cyc.size()), 32'd0);

    // 3-byte push ending the script: consecutive bytes then a single evaluate pulse.
    run_item(mk_item(0, 8'h00, 3, 512'hAABBCC, 1));
    check("p3_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("p3_cycle", 32'(got_cyc[i] - acc_cyc), 32'(i));
      check("p3_b0", 32'(got_q[0]), 32'h03);
      check("p3_b1", 32'(got_q[1]), 32'hAA);
      check("p3_b2", 32'(got_q[2]), 32'hBB);
      check("p3_b3", 32'(got_q[3]), 32'hCC);
    end
    check("p3_eval_n", 32'(eval_cyc.size()), 32'd1);
    if (eval_cyc.size() == 1) check("p3_eval_cyc", 32'(eval_cyc[0] - acc_cyc), 32'd4);

    // Stall the sink for two cycles on 0xAA.
    got_q.delete(); got_cyc.delete(); eval_cyc.delete();
    send_item(mk_item(0, 8'h00, 3, 512'hAABBCC, 1), ok);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk); check("stall_aa0", 32'(bus.script_data), 32'hAA);
    @(posedge clk); #1;
    @(negedge clk); check("stall_aa1", 32'(bus.script_data), 32'hAA);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk); check("stall_aa2", 32'(bus.script_data), 32'hAA);
    check("stall_put", 32'(bus.script_put), 32'd1);
    wait_done(ok);
    check("stall_done", 32'(ok), 32'd1);
    check("stall_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) check("stall_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'h03AABBCC);
    check("stall_eval", 32'(eval_cyc.size()), 32'd1);

    // Vector table.
    foreach (vecs[k]) begin
      run_item(vecs[k].it);
      check($sformatf("vec%0d_n", k), 32'(got_q.size()), 32'(vecs[k].exp_n));
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_first", k), 32'(got_q[0]), 32'(vecs[k].exp_first));
        check($sformatf("vec%0d_last", k), 32'(got_q[got_q.size()-1]), 32'(vecs[k].exp_lastb));
      end
      check($sformatf("vec%0d_eval", k), 32'(eval_cyc.size()), 32'(vecs[k].exp_eval));
      check($sformatf("vec%0d_err", k), 32'(error), 32'd0);
    end

    // Reset in the middle of a push.
    got_q.delete(); got_cyc.delete(); eval_cyc.delete();
    send_item(mk_item(0, 8'h00, 3, 512'hAABBCC, 1), ok);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_put", 32'(bus.script_put), 32'd0);
    check("mrst_data", 32'(bus.script_data), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) check("mrst_bytes", {16'h0, got_q[0], got_q[1]}, 32'h03AA);
    check("mrst_no_eval", 32'(eval_cyc.size()), 32'd0);
    check("mrst_ready_back", 32'(bus.in_ready), 32'd1);

    // Encoding errors are sticky until reset and emit nothing.
    for (int e = 0; e < 3; e++) begin
      got_q.delete(); got_cyc.delete(); eval_cyc.delete();
      case (e)
        0:       it = mk_item(1, 8'h20, 0, '0, 1);
        1:       it = mk_item(0, 8'h00, 65, '1, 1);
        default: it = mk_item(1, 8'h01, 0, '0, 0);
      endcase
      send_item(it, ok);
      @(negedge clk);
      check($sformatf("err%0d_flag", e), 32'(error), 32'd1);
      check($sformatf("err%0d_ready", e), 32'(bus.in_ready), 32'd0);
      repeat (5) @(negedge clk);
      check($sformatf("err%0d_flag_hold", e), 32'(error), 32'd1);
      check($sformatf("err%0d_ready_hold", e), 32'(bus.in_ready), 32'd0);
      check($sformatf("err%0d_no_put", e), 32'(got_q.size()), 32'd0);
      check($sformatf("err%0d_no_eval", e), 32'(eval_cyc.size()), 32'd0);
      reset_dut();
      @(negedge clk);
      check($sformatf("err%0d_cleared", e), 32'(error), 32'd0);
    end

    // Random items with random sink back-pressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      int r;
      it.is_op = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r == 0) it.op = 8'($urandom_range(1, 75));
      else        it.op = 8'($urandom_range(76, 256));
      for (int k = 0; k < 16; k++) it.data[32*k +: 32] = $urandom();
      r = $urandom_range(0, 19);
      if (r == 0)      it.len = 7'($urandom_range(65, 127));
      else if (r == 1) it.len = 7'd0;
      else if (r < 6) begin
        it.len = 7'd1;
        it.data[7:0] = ($urandom_range(0, 3) == 0) ? 8'h81 : 8'($urandom_range(0, 20));
      end else         it.len = 7'($urandom_range(1, 64));
      it.last = ($urandom_range(0, 2) == 0);
      model(it, exp_err, exp_q);
      run_item(it);
      check($sformatf("rnd%0d_err", t), 32'(error), 32'(exp_err));
      check($sformatf("rnd%0d_n", t), 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check($sformatf("rnd%0d_b%0d", t, i), 32'(got_q[i]), 32'(exp_q[i]));
      check($sformatf("rnd%0d_eval", t), 32'(eval_cyc.size()), 32'((it.last && !exp_err) ? 1 : 0));
      if (exp_err || error) reset_dut();
    end
    rand_ready = 1'b0;
    @(posedge clk); #2 bus.out_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
